// File: rtl/fpu_rnd_arb_if.sv
// Bus bundle for the FPU rounder arbiter: two requester channels, the
// launch/return path to the shared rounder, and the result FIFO head.
interface fpu_rnd_arb_if #(
   parameter int TAG_W = 4
);
   // requester side
   logic [1:0]             req_valid_i;
   logic [1:0]             req_ready_o;
   logic [1:0][56:0]       req_data_i;
   logic [1:0][2:0]        req_grs_i;
   logic [1:0][TAG_W-1:0]  req_tag_i;
   logic [2:0]             rmode_i;
   // shared rounder side
   logic [56:0]            rnd_data_o;
   logic [2:0]             rnd_grs_o;
   logic [2:0]             rnd_rmode_o;
   logic [31:0]            rnd_result_i;
   // result side
   logic                   res_valid_o;
   logic                   res_ready_i;
   logic [31:0]            res_data_o;
   logic                   res_src_o;
   logic [TAG_W-1:0]       res_tag_o;
   logic                   busy_o;

   // the arbiter itself
   modport slave (
      input  req_valid_i, req_data_i, req_grs_i, req_tag_i, rmode_i,
      input  rnd_result_i, res_ready_i,
      output req_ready_o, rnd_data_o, rnd_grs_o, rnd_rmode_o,
      output res_valid_o, res_data_o, res_src_o, res_tag_o, busy_o
   );

   // requesters, rounder and consumer around the arbiter
   modport master (
      output req_valid_i, req_data_i, req_grs_i, req_tag_i, rmode_i,
      output rnd_result_i, res_ready_i,
      input  req_ready_o, rnd_data_o, rnd_grs_o, rnd_rmode_o,
      input  res_valid_o, res_data_o, res_src_o, res_tag_o, busy_o
   );
endinterface

// File: rtl/fpu_rnd_arb.sv
// Round-robin arbiter sharing one single-precision rounder between the adder
// (requester 0) and the multiplier (requester 1). Accepted operands are
// launched to the rounder, the result returns two edges later and is queued
// with its source index and tag in a small result FIFO. Credit counts every
// operand in flight plus every queued result, so the FIFO can never overflow.
module fpu_rnd_arb #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   fpu_rnd_arb_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = 32 + 1 + TAG_W;

   // arbitration
   logic [1:0]       grant;
   logic             sel;
   logic             accept;
   logic             credit;
   logic [CNT_W:0]   occ;
   logic             last_q;

   // launch stage (p1) and return stage (p2)
   logic [56:0]      rnd_data_p1_q;
   logic [2:0]       rnd_grs_p1_q;
   logic [2:0]       rnd_rmode_p1_q;
   logic             vld_p1_q;
   logic             src_p1_q;
   logic [TAG_W-1:0] tag_p1_q;
   logic             vld_p2_q;
   logic             src_p2_q;
   logic [TAG_W-1:0] tag_p2_q;

   // result FIFO
   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push;
   logic             pop;
   logic             res_valid;
   logic [ENT_W-1:0] head;

   // Grant one requester per cycle; ties go to the one not granted last.
   always_comb begin
      occ    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, vld_p1_q} + {{CNT_W{1'b0}}, vld_p2_q};
      credit = occ < (CNT_W + 1)'(DEPTH);
      grant  = 2'b00;
      if (!rst_i && credit) begin
         case (bus.req_valid_i)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   assign sel    = grant[1];
   assign accept = |grant;

   // Stage p1: launch the granted operand to the rounder and track occupancy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q         <= 1'b1;
         vld_p1_q       <= 1'b0;
         vld_p2_q       <= 1'b0;
         rnd_data_p1_q  <= '0;
         rnd_grs_p1_q   <= '0;
         rnd_rmode_p1_q <= '0;
      end else begin
         vld_p1_q <= accept;
         vld_p2_q <= vld_p1_q;
         if (accept) begin
            last_q         <= sel;
            rnd_data_p1_q  <= bus.req_data_i[sel];
            rnd_grs_p1_q   <= bus.req_grs_i[sel];
            rnd_rmode_p1_q <= bus.rmode_i;
         end
      end
   end

   // Stage p1 -> p2: carry source index and tag alongside the rounder latency.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         src_p1_q <= sel;
         tag_p1_q <= bus.req_tag_i[sel];
      end
      src_p2_q <= src_p1_q;
      tag_p2_q <= tag_p1_q;
   end

   assign bus.req_ready_o = grant;
   assign bus.rnd_data_o  = rnd_data_p1_q;
   assign bus.rnd_grs_o   = rnd_grs_p1_q;
   assign bus.rnd_rmode_o = rnd_rmode_p1_q;

   assign push = vld_p2_q;
   assign pop  = res_valid && bus.res_ready_i;

   // FIFO next-state: circular pointers that wrap explicitly at DEPTH-1.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // FIFO control state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Stage p2 -> FIFO: capture the rounder result with its sideband.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {bus.rnd_result_i, src_p2_q, tag_p2_q};
      end
   end

   // Head is read straight from storage so it holds while the consumer stalls;
   // outputs are forced to zero whenever no valid result is presented.
   assign head            = mem_q[rd_ptr_q];
   assign res_valid       = (cnt_q != '0) && !rst_i;
   assign bus.res_valid_o = res_valid;
   assign bus.res_data_o  = res_valid ? head[ENT_W-1 -: 32] : 32'h0;
   assign bus.res_src_o   = res_valid ? head[TAG_W] : 1'b0;
   assign bus.res_tag_o   = res_valid ? head[TAG_W-1:0] : '0;
   assign bus.busy_o      = !rst_i && (vld_p1_q || vld_p2_q || (cnt_q != '0));
endmodule

// File: doc/fpu_rnd_arb.md
FPU_RND_ARB -- requirements
Module: fpu_rnd_arb

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning result FIFO entries (legal range 4..16).
REQ-002 The block SHALL have parameter TAG_W, default 4, meaning the width of the requester transaction tag.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid_i, input, 2 bits: per-requester request valid (bit 0 = adder, bit 1 = multiplier).
REQ-006 The block SHALL have port req_ready_o, output, 2 bits: per-requester grant; a transfer occurs when valid and ready are both 1.
REQ-007 The block SHALL have port req_data_i, input, 2x57 bits: unrounded {sign, exp[7:0], mant[47:0]} per requester.
REQ-008 The block SHALL have port req_grs_i, input, 2x3 bits: per-requester {guard, round, sticky}.
REQ-009 The block SHALL have port req_tag_i, input, 2xTAG_W bits: per-requester transaction tag.
REQ-010 The block SHALL have port rmode_i, input, 3 bits: rounding mode, sampled per accepted request.
REQ-011 The block SHALL have port rnd_data_o, output, 57 bits: registered data driven to the rounder.
REQ-012 The block SHALL have port rnd_grs_o, output, 3 bits: registered grs driven to the rounder.
REQ-013 The block SHALL have port rnd_rmode_o, output, 3 bits: registered rounding mode driven to the rounder.
REQ-014 The block SHALL have port rnd_result_i, input, 32 bits: rounder output, valid one cycle after rnd_*_o.
REQ-015 The block SHALL have port res_valid_o, output, 1 bit: the FIFO head is valid.
REQ-016 The block SHALL have port res_ready_i, input, 1 bit: consumer accepts the FIFO head.
REQ-017 The block SHALL have port res_data_o, output, 32 bits: rounded single-precision result.
REQ-018 The block SHALL have port res_src_o, output, 1 bit: index of the requester that produced the result.
REQ-019 The block SHALL have port res_tag_o, output, TAG_W bits: tag of the result.
REQ-020 The block SHALL have port busy_o, output, 1 bit: any stage or FIFO entry occupied.

Function
REQ-021 At most one request SHALL be accepted per cycle; req_ready_o SHALL be one-hot or zero, combinational from req_valid_i, the arbitration pointer, and credit.
REQ-022 Arbitration SHALL be round-robin: when both requesters are valid, the one not granted most recently wins; a single valid requester SHALL win regardless of the pointer.
REQ-023 The pointer SHALL update only on an accepted transfer, to the accepted index.
REQ-024 Credit SHALL be held when fifo_count + s1_valid + s2_valid < DEPTH; the current-cycle FIFO pop SHALL NOT be credited; with no credit, req_ready_o = 2'b00.
REQ-025 Stage S1: on accept at edge E, {data, grs, rmode_i} SHALL be registered onto rnd_*_o, and {src, tag} into S1 sideband, with s1_valid set.
REQ-026 Stage S2: at edge E+1, S1 sideband SHALL move to S2 and s2_valid SHALL equal the prior s1_valid; the rounder registers its result at this edge.
REQ-027 At edge E+2, with s2_valid, {rnd_result_i, src, tag} SHALL be written to the FIFO; res_valid_o SHALL be 1 from cycle E+3 at the earliest (accept-to-result latency of 3 cycles).
REQ-028 With no accept, rnd_*_o SHALL hold the previous values and s1_valid SHALL clear.
REQ-029 The FIFO SHALL be first-in first-out with circular read/write pointers wrapping at DEPTH-1 to 0; a simultaneous push and pop SHALL leave the count unchanged.
REQ-030 res_data_o, res_src_o, and res_tag_o SHALL remain stable while res_valid_o=1 and res_ready_i=0.
REQ-031 A push into a full FIFO SHALL be impossible by construction of the credit; the bench asserts this.
REQ-032 busy_o SHALL equal s1_valid | s2_valid | (fifo_count != 0).
REQ-033 Back-to-back accepts SHALL sustain one result per cycle when res_ready_i=1 continuously.

Reset
REQ-034 While rst_i=1 at an edge, the block SHALL clear s1_valid, s2_valid, FIFO pointers and count, and set the pointer to favour requester 0.
REQ-035 While rst_i=1 at an edge, the block SHALL set rnd_data_o=0, rnd_grs_o=0, and rnd_rmode_o=0.
REQ-036 During reset, req_ready_o SHALL be 00, res_valid_o=0, busy_o=0, and res_data_o, res_src_o, res_tag_o = 0.
REQ-037 Reset mid-operation SHALL discard all in-flight and queued results without emitting them.

Verification
REQ-038 Single request: adder req tag=3, data={0,8'h7F,48'h800000000000}, grs=000, rmode=001, accepted at E -> res_valid_o at E+3, res_data_o=32'h3F800000, res_src_o=0, res_tag_o=3.
REQ-039 Contention: both valid for 4 cycles, pointer favouring 0 -> grants 0,1,0,1; results in that order with matching tags.
REQ-040 Backpressure: res_ready_i=0 and both requesters valid continuously -> exactly DEPTH accepts, then req_ready_o=00; raise res_ready_i -> head pops, and a new accept occurs the cycle after the first pop.
REQ-041 Streaming: requester 1 valid for 10 cycles with res_ready_i=1 -> 10 accepts in 10 consecutive cycles and 10 results in consecutive cycles starting at E+3.
REQ-042 Reset mid-flight: 3 requests in flight, assert rst_i one cycle -> res_valid_o=0 and busy_o=0 after the edge, and no stale result appears afterwards.
